pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/geo_pkg.sv | 25 ++
 rtl/pixel_fifo.sv | 60 ++++++
 rtl/pixel_writer.sv | 145 ++++++++++++++
 tb/tb_pixel_writer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/geo_pkg.sv
// Shared types for the pixel writer: FSM state encoding, FIFO entry layout
// and the saturating clip-counter increment.
package geo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int unsigned COORD_W  = 12;
    localparam int unsigned COLOUR_W = 8;
    localparam logic [15:0] CLIP_MAX = 16'hFFFF;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic [COLOUR_W-1:0]       colour;
    } pixel_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == CLIP_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with a parameterised entry type; DEPTH must be a power of
// two so the pointers wrap for free.
module pixel_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = logic [31:0]
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// Buffers incoming pixels and turns each into one byte write at
// base_addr + Y*dest_width + X. Clipping is enabled by PIXEL_WRITER_CLIP_EN.
module pixel_writer
    import geo_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 20
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pixel_data_rdy,
    input  logic signed [11:0]  X_coord,
    input  logic signed [11:0]  Y_coord,
    input  logic [7:0]          colour,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [11:0]         dest_width,
    input  logic [11:0]         dest_height,
    output logic                draw_busy,
    output logic                wr_ena,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [7:0]          wr_data,
    input  logic                wr_ack,
    output logic [15:0]         clip_count
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    state_t             state;
    pixel_t             cur;
    pixel_t             in_pixel;
    pixel_t             head;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               unused_full;
    logic [CNT_W-1:0]   occ;
    logic [CNT_W-1:0]   occ_next;
    logic [ADDR_W-1:0]  x_ext;
    logic [ADDR_W-1:0]  y_ext;
    logic [ADDR_W-1:0]  w_ext;
    logic [ADDR_W-1:0]  addr_calc;
    logic               clip_hit;

    assign in_pixel = '{x: X_coord, y: Y_coord, colour: colour};
    assign push     = pixel_data_rdy && !draw_busy;
    assign pop      = (state == IDLE) && !fifo_empty;

    pixel_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (pixel_t)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (in_pixel),
        .pop       (pop),
        .pop_data  (head),
        .full      (unused_full),
        .empty     (fifo_empty),
        .count     (occ)
    );

    // draw_busy is registered from the post-edge occupancy so a push can never
    // be offered into a full FIFO.
    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + 1'b1;
        end else if (!push && pop) begin
            occ_next = occ - 1'b1;
        end
    end

    // Sign extension makes unclipped negative coordinates wrap modulo 2^ADDR_W.
    assign x_ext     = ADDR_W'(cur.x);
    assign y_ext     = ADDR_W'(cur.y);
    assign w_ext     = ADDR_W'(dest_width);
    assign addr_calc = base_addr + y_ext * w_ext + x_ext;

`ifdef PIXEL_WRITER_CLIP_EN
    logic [11:0] x_u;
    logic [11:0] y_u;

    assign x_u      = cur.x;
    assign y_u      = cur.y;
    assign clip_hit = cur.x[11] || cur.y[11] || (x_u >= dest_width) || (y_u >= dest_height);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clip_count <= '0;
        end else if (state == CALC && clip_hit) begin
            clip_count <= sat_inc16(clip_count);
        end
    end
`else
    logic unused_height;

    assign unused_height = ^dest_height;
    assign clip_hit      = 1'b0;
    assign clip_count    = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur       <= '0;
            draw_busy <= 1'b0;
            wr_ena    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            draw_busy <= (occ_next == DEPTH_C);
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cur   <= head;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (clip_hit) begin
                        state <= IDLE;
                    end else begin
                        wr_addr <= addr_calc;
                        wr_data <= cur.colour;
                        wr_ena  <= 1'b1;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr_ack) begin
                        wr_ena <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    wr_ena <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer; clipping scenarios follow PIXEL_WRITER_CLIP_EN.
module tb_pixel_writer;

    localparam int unsigned ADDR_W = 20;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               pixel_data_rdy = 1'b0;
    logic signed [11:0] X_coord = '0;
    logic signed [11:0] Y_coord = '0;
    logic [7:0]         colour = '0;
    logic [ADDR_W-1:0]  base_addr = 20'h01000;
    logic [11:0]        dest_width = 12'd640;
    logic [11:0]        dest_height = 12'd480;
    logic               draw_busy;
    logic               wr_ena;
    logic [ADDR_W-1:0]  wr_addr;
    logic [7:0]         wr_data;
    logic               wr_ack = 1'b0;
    logic [15:0]        clip_count;

    int checks = 0;
    int failures = 0;
    logic [ADDR_W+7:0] wr_q[$];

    always #5 clk = ~clk;

    pixel_writer #(
        .FIFO_DEPTH (4),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pixel_data_rdy (pixel_data_rdy),
        .X_coord        (X_coord),
        .Y_coord        (Y_coord),
        .colour         (colour),
        .base_addr      (base_addr),
        .dest_width     (dest_width),
        .dest_height    (dest_height),
        .draw_busy      (draw_busy),
        .wr_ena         (wr_ena),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .clip_count     (clip_count)
    );

    // Writes accepted at the following rising edge are logged mid-cycle.
    always @(negedge clk) begin
        if (reset_n && wr_ena && wr_ack) wr_q.push_back({wr_addr, wr_data});
    end

    task automatic do_reset();
        reset_n = 1'b0;
        pixel_data_rdy = 1'b0;
        wr_ack = 1'b0;
        base_addr = 20'h01000;
        dest_width = 12'd640;
        dest_height = 12'd480;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        wr_q.delete();
    endtask

    task automatic push_pixel(input int x, input int y, input logic [7:0] c, output bit ok);
        int n = 0;
        X_coord = 12'(x);
        Y_coord = 12'(y);
        colour = c;
        pixel_data_rdy = 1'b1;
        while (draw_busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        ok = !draw_busy;
        @(posedge clk); #1;
        pixel_data_rdy = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int max_cyc, output bit ok);
        int k = 0;
        while (wr_q.size() < n && k < max_cyc) begin
            @(posedge clk); #1;
            k++;
        end
        ok = (wr_q.size() >= n);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (draw_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", draw_busy); end
        checks++; if (wr_ena !== 1'b0) begin failures++; $display("FAIL reset_wr_ena got=%b exp=0", wr_ena); end
        checks++; if (wr_addr !== 20'h0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
        checks++; if (wr_data !== 8'h0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
        checks++; if (clip_count !== 16'h0) begin failures++; $display("FAIL reset_clip got=%h exp=0", clip_count); end
    endtask

    task automatic test_single_write();
        do_reset();
        wr_ack = 1'b1;
        X_coord = 12'sd10;
        Y_coord = 12'sd2;
        colour = 8'h5A;
        pixel_data_rdy = 1'b1;
        @(posedge clk); #1;
        pixel_data_rdy = 1'b0;
        @(posedge clk); #1;
        checks++; if (wr_ena !== 1'b0) begin failures++; $display("FAIL lat_k1 wr_ena=%b exp=0", wr_ena); end
        @(posedge clk); #1;
        checks++; if (wr_ena !== 1'b1) begin failures++; $display("FAIL lat_k2 wr_ena=%b exp=1", wr_ena); end
        checks++; if (wr_addr !== 20'h0150A) begin failures++; $display("FAIL single_addr got=%h exp=0150a", wr_addr); end
        checks++; if (wr_data !== 8'h5A) begin failures++; $display("FAIL single_data got=%h exp=5a", wr_data); end
        @(posedge clk); #1;
        checks++; if (wr_ena !== 1'b0) begin failures++; $display("FAIL single_drop wr_ena=%b exp=0", wr_ena); end
        repeat (4) @(posedge clk); #1;
        checks++; if (wr_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", wr_q.size()); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int cyc = 0;
        int busy_at = -1;
        bit acc;
        logic [ADDR_W+7:0] exp_w;
        logic [ADDR_W-1:0] stall_addr = 'x;
        logic stall_ena = 1'bx;
        logic stall_busy = 1'bx;
        do_reset();
        while ((idx < 8 || wr_q.size() < 8) && cyc < 300) begin
            if (cyc == 20) wr_ack = 1'b1;
            if (idx < 8) begin
                X_coord = 12'(10 + idx);
                Y_coord = 12'(idx);
                colour = 8'(8'h10 + idx);
                pixel_data_rdy = 1'b1;
            end else begin
                pixel_data_rdy = 1'b0;
            end
            acc = (idx < 8) && !draw_busy;
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
            if (draw_busy && busy_at < 0) busy_at = idx;
            if (cyc == 19) begin
                stall_addr = wr_addr;
                stall_ena = wr_ena;
                stall_busy = draw_busy;
            end
        end
        pixel_data_rdy = 1'b0;
        repeat (10) @(posedge clk); #1;
        // Four entries sit in the FIFO and one is held by the write engine.
        checks++; if (busy_at != 5) begin failures++; $display("FAIL bp_busy_at got=%0d exp=5", busy_at); end
        checks++; if (stall_busy !== 1'b1) begin failures++; $display("FAIL bp_stall_busy got=%b exp=1", stall_busy); end
        checks++; if (stall_ena !== 1'b1) begin failures++; $display("FAIL bp_stall_ena got=%b exp=1", stall_ena); end
        checks++; if (stall_addr !== 20'h0100A) begin failures++; $display("FAIL bp_stall_addr got=%h exp=0100a", stall_addr); end
        checks++; if (wr_q.size() != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", wr_q.size()); end
        for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
            exp_w = {ADDR_W'(32'h1000 + i * 640 + 10 + i), 8'(8'h10 + i)};
            checks++;
            if (wr_q[i] !== exp_w) begin
                failures++;
                $display("FAIL bp_write%0d got=%h exp=%h", i, wr_q[i], exp_w);
            end
        end
    endtask

    task automatic test_push_pop_same_edge();
        bit ok;
        bit all_ok = 1'b1;
        do_reset();
        push_pixel(1, 1, 8'hA1, ok); all_ok &= ok;
        push_pixel(2, 1, 8'hA2, ok); all_ok &= ok;
        push_pixel(3, 1, 8'hA3, ok); all_ok &= ok;
        checks++; if (dut.u_fifo.count !== 3'd2) begin failures++; $display("FAIL pp_pre_occ got=%0d exp=2", dut.u_fifo.count); end
        wr_ack = 1'b1;
        @(posedge clk); #1;
        X_coord = 12'sd4;
        Y_coord = 12'sd1;
        colour = 8'hA4;
        pixel_data_rdy = 1'b1;
        @(posedge clk); #1;
        pixel_data_rdy = 1'b0;
        checks++; if (dut.u_fifo.count !== 3'd2) begin failures++; $display("FAIL pp_occ got=%0d exp=2", dut.u_fifo.count); end
        checks++; if (draw_busy !== 1'b0) begin failures++; $display("FAIL pp_busy got=%b exp=0", draw_busy); end
        wait_writes(4, 50, ok); all_ok &= ok;
        checks++; if (!all_ok) begin failures++; $display("FAIL pp_timeout got=0 exp=1"); end
        checks++;
        if (wr_q.size() < 4 || wr_q[3] !== {20'h01284, 8'hA4}) begin
            failures++;
            $display("FAIL pp_last_write got=%h exp=%h", (wr_q.size() >= 4) ? wr_q[3] : 28'h0, {20'h01284, 8'hA4});
        end
    endtask

    task automatic test_reset_in_write();
        bit ok;
        bit all_ok = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_pixel(i, 0, 8'(8'hC0 + i), ok);
            all_ok &= ok;
        end
        checks++; if (wr_ena !== 1'b1) begin failures++; $display("FAIL rw_pre_ena got=%b exp=1", wr_ena); end
        checks++; if (dut.u_fifo.count !== 3'd3) begin failures++; $display("FAIL rw_pre_occ got=%0d exp=3", dut.u_fifo.count); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (wr_ena !== 1'b0) begin failures++; $display("FAIL rw_async_ena got=%b exp=0", wr_ena); end
        checks++; if (wr_addr !== 20'h0) begin failures++; $display("FAIL rw_async_addr got=%h exp=0", wr_addr); end
        wr_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        wr_q.delete();
        repeat (10) @(posedge clk); #1;
        checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL rw_no_retry got=%0d exp=0", wr_q.size()); end
        checks++; if (dut.u_fifo.count !== 3'd0) begin failures++; $display("FAIL rw_fifo_empty got=%0d exp=0", dut.u_fifo.count); end
        push_pixel(7, 1, 8'h77, ok); all_ok &= ok;
        wait_writes(1, 20, ok); all_ok &= ok;
        checks++; if (!all_ok) begin failures++; $display("FAIL rw_timeout got=0 exp=1"); end
        checks++;
        if (wr_q.size() != 1 || wr_q[0] !== {20'h01287, 8'h77}) begin
            failures++;
            $display("FAIL rw_new_write got=%h n=%0d exp=%h", (wr_q.size() > 0) ? wr_q[0] : 28'h0, wr_q.size(), {20'h01287, 8'h77});
        end
    endtask

`ifdef PIXEL_WRITER_CLIP_EN
    task automatic test_clip();
        bit ok;
        bit all_ok = 1'b1;
        do_reset();
        wr_ack = 1'b1;
        push_pixel(-1, 0, 8'h01, ok);  all_ok &= ok;
        push_pixel(640, 5, 8'h02, ok); all_ok &= ok;
        push_pixel(3, 480, 8'h03, ok); all_ok &= ok;
        push_pixel(3, 4, 8'h04, ok);   all_ok &= ok;
        wait_writes(1, 50, ok); all_ok &= ok;
        repeat (10) @(posedge clk); #1;
        checks++; if (!all_ok) begin failures++; $display("FAIL clip_timeout got=0 exp=1"); end
        checks++; if (wr_q.size() != 1) begin failures++; $display("FAIL clip_count_writes got=%0d exp=1", wr_q.size()); end
        checks++;
        if (wr_q.size() == 0 || wr_q[0] !== {20'h01A03, 8'h04}) begin
            failures++;
            $display("FAIL clip_write got=%h exp=%h", (wr_q.size() > 0) ? wr_q[0] : 28'h0, {20'h01A03, 8'h04});
        end
        checks++; if (clip_count !== 16'd3) begin failures++; $display("FAIL clip_cnt got=%0d exp=3", clip_count); end
    endtask

    task automatic test_clip_saturation();
        int accepted = 0;
        int cyc = 0;
        bit acc;
        do_reset();
        wr_ack = 1'b1;
        X_coord = -12'sd1;
        Y_coord = 12'sd0;
        colour = 8'hEE;
        pixel_data_rdy = 1'b1;
        while (accepted < 65540 && cyc < 200000) begin
            acc = !draw_busy;
            @(posedge clk); #1;
            cyc++;
            if (acc) accepted++;
        end
        pixel_data_rdy = 1'b0;
        repeat (20) @(posedge clk); #1;
        checks++; if (accepted != 65540) begin failures++; $display("FAIL sat_pushes got=%0d exp=65540", accepted); end
        checks++; if (clip_count !== 16'hFFFF) begin failures++; $display("FAIL sat_clip got=%h exp=ffff", clip_count); end
        checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL sat_writes got=%0d exp=0", wr_q.size()); end
    endtask
`else
    task automatic test_no_clip();
        bit ok;
        bit all_ok = 1'b1;
        logic [ADDR_W+7:0] exp_w [3];
        exp_w[0] = {20'h00FFF, 8'h11};
        exp_w[1] = {20'h4C003, 8'h22};
        exp_w[2] = {20'h00D7F, 8'h33};
        do_reset();
        wr_ack = 1'b1;
        push_pixel(-1, 0, 8'h11, ok);  all_ok &= ok;
        push_pixel(3, 480, 8'h22, ok); all_ok &= ok;
        push_pixel(-1, -1, 8'h33, ok); all_ok &= ok;
        wait_writes(3, 50, ok); all_ok &= ok;
        checks++; if (!all_ok) begin failures++; $display("FAIL noclip_timeout got=0 exp=1"); end
        for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL noclip_write%0d got=%h exp=%h", i, wr_q[i], exp_w[i]);
            end
        end
        checks++; if (clip_count !== 16'h0) begin failures++; $display("FAIL noclip_cnt got=%h exp=0", clip_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_backpressure();
        test_push_pop_same_edge();
        test_reset_in_write();
`ifdef PIXEL_WRITER_CLIP_EN
        test_clip();
        test_clip_saturation();
`else
        test_no_clip();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
